// File: rtl/uio_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uio_tx_pkg
// Brief    : Shared types and constants for the uio parallel byte transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uio_tx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        STROBE  = 3'd2,
        ACK_LO  = 3'd3,
        RELEASE = 3'd4
    } state_t;

    localparam logic [7:0] OE_DRIVE   = 8'hFF;
    localparam logic [7:0] OE_RELEASE = 8'h00;

endpackage : uio_tx_pkg
`default_nettype wire

// File: rtl/uio_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uio_tx_fifo
// Brief    : Synchronous show-ahead FIFO, DEPTH x 8, wrap-bit pointers.
// Revision : 1.0 - initial release
// ============================================================================
module uio_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               wdata,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    logic        w_push;
    logic        w_pop;

    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage carries no reset; emptiness is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    assign rdata = r_mem[r_rptr[AW-1:0]];
    assign empty = (r_wptr == r_rptr);
    assign full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign level = r_wptr - r_rptr;

endmodule : uio_tx_fifo
`default_nettype wire

// File: rtl/uio_par_tx.sv
`default_nettype none
// ============================================================================
// Module   : uio_par_tx
// Brief    : Parallel byte transmitter on the uio pad bus, 4-phase stb/ack.
// Revision : 1.0 - initial release
// ============================================================================
module uio_par_tx
    import uio_tx_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 2,
    parameter int TIMEOUT   = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     err_clr,
    output logic [7:0]               pad_out,
    output logic [7:0]               pad_oe,
    output logic                     pad_stb,
    input  logic                     pad_ack,
    output logic                     busy,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int CNT_MAX = (TIMEOUT > SETUP_CYC) ? TIMEOUT : SETUP_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] C_SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] C_TMO_LAST   = CW'(TIMEOUT - 1);

    state_t         r_state;
    state_t         w_next;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_next;
    logic           r_ack_meta;
    logic           r_ack_s;
    logic           w_push;
    logic           w_pop;
    logic           w_tmo;
    logic           w_full;
    logic           w_empty;
    logic [7:0]     w_head;

    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign busy     = (r_state != IDLE) || !w_empty;

    uio_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (in_data),
        .rdata (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= pad_ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // One counter serves both the setup delay and the ack-wait timeout.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_pop      = 1'b0;
        w_tmo      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty && !r_ack_s) begin
                    w_next     = SETUP;
                    w_cnt_next = '0;
                end
            end
            SETUP: begin
                if (r_cnt == C_SETUP_LAST) begin
                    w_next     = STROBE;
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            STROBE: begin
                if (r_ack_s) begin
                    w_pop      = 1'b1;
                    w_next     = ACK_LO;
                    w_cnt_next = '0;
                end else if (r_cnt == C_TMO_LAST) begin
                    w_pop  = 1'b1;
                    w_tmo  = 1'b1;
                    w_next = RELEASE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ACK_LO: begin
                if (!r_ack_s) begin
                    w_next     = w_empty ? RELEASE : SETUP;
                    w_cnt_next = '0;
                end else if (r_cnt == C_TMO_LAST) begin
                    w_tmo  = 1'b1;
                    w_next = RELEASE;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            RELEASE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Pad outputs are registered from the next state so they switch with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_out <= 8'h00;
            pad_oe  <= OE_RELEASE;
            pad_stb <= 1'b0;
            err     <= 1'b0;
        end else begin
            pad_stb <= (w_next == STROBE);
            pad_oe  <= (w_next inside {SETUP, STROBE, ACK_LO}) ? OE_DRIVE : OE_RELEASE;
            if (w_next == SETUP) begin
                pad_out <= w_head;
            end else if ((w_next == IDLE) || (w_next == RELEASE)) begin
                pad_out <= 8'h00;
            end
            if (w_tmo) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end

endmodule : uio_par_tx
`default_nettype wire
